// File: rtl/intf_array_rr_arb.sv
// intf_array_rr_arb: N-channel stream concentrator.
// Each channel has its own FIFO built in a genvar loop. A round-robin arbiter
// feeds one registered output stage.
// Optional feature macro: INTF_ARB_PKT_EN. When it is defined, the arbiter
// locks onto a channel from a beat with last=0 until it loads a beat with
// last=1. When it is undefined, every beat arbitrates on its own and in_last
// is only carried through to out_last.
module intf_array_rr_arb #(
   parameter int NCH   = 2,
   parameter int W     = 8,
   parameter int DEPTH = 4,
   localparam int CW   = $clog2(NCH),
   localparam int FW   = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH-1:0]    in_valid,
   output logic [NCH-1:0]    in_ready,
   input  logic [NCH*W-1:0]  in_data,
   input  logic [NCH-1:0]    in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W-1:0]      out_data,
   output logic [CW-1:0]     out_chan,
   output logic              out_last,
   output logic [NCH*FW-1:0] fill
);

   localparam int            AW      = $clog2(DEPTH);
   localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

   logic [NCH-1:0] pop_s;
   logic [NCH-1:0] nonempty_s;
   logic [NCH-1:0] head_last_s;
   logic [W-1:0]   head_data_s [NCH];

   logic [CW-1:0]  rr_r;
   logic [CW-1:0]  pick_s;
   logic           found_s;
   logic           load_s;
   logic           take_s;

   // ---------------------------------------------------------------------
   // Per-channel FIFOs
   // ---------------------------------------------------------------------
   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [W:0]    mem_r [DEPTH];
      logic [AW-1:0] wr_ptr_r;
      logic [AW-1:0] rd_ptr_r;
      logic [FW-1:0] count_r;
      logic          push_s;

      // A full FIFO refuses the push even when it is popped in the same cycle.
      assign in_ready[c]        = (count_r < FW'(DEPTH));
      assign push_s             = in_valid[c] & in_ready[c];
      assign nonempty_s[c]      = (count_r != FW'(0));
      assign head_data_s[c]     = mem_r[rd_ptr_r][W-1:0];
      assign head_last_s[c]     = mem_r[rd_ptr_r][W];
      assign fill[c*FW +: FW]   = count_r;

      // Beat storage: the last flag is kept beside the data.
      always_ff @(posedge clk) begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= {in_last[c], in_data[c*W +: W]};
         end
      end

      // Pointers wrap at DEPTH naturally because DEPTH is a power of two.
      always_ff @(posedge clk) begin
         if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= FW'(0);
         end else begin
            if (push_s) begin
               wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s[c]) begin
               rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s[c]})
               2'b10:   count_r <= count_r + FW'(1);
               2'b01:   count_r <= count_r - FW'(1);
               default: count_r <= count_r;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------
   // Optional packet-lock FSM
   // ---------------------------------------------------------------------
`ifdef INTF_ARB_PKT_EN
   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t        state_r;
   state_t        state_next_s;
   logic [CW-1:0] lock_ch_r;
   logic [CW-1:0] lock_ch_next_s;

   // State register for the packet lock.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         lock_ch_r <= CW'(0);
      end else begin
         state_r   <= state_next_s;
         lock_ch_r <= lock_ch_next_s;
      end
   end

   // Next state: lock on a beat with last=0; release on a beat with last=1.
   always_comb begin
      state_next_s   = state_r;
      lock_ch_next_s = lock_ch_r;
      if (take_s) begin
         if (head_last_s[pick_s]) begin
            state_next_s = IDLE;
         end else begin
            state_next_s   = LOCKED;
            lock_ch_next_s = pick_s;
         end
      end else begin
         state_next_s   = state_r;
         lock_ch_next_s = lock_ch_r;
      end
   end
`endif

   // ---------------------------------------------------------------------
   // Arbiter
   // ---------------------------------------------------------------------
   // Search rr+1, rr+2 ... modulo NCH, wrapping explicitly because NCH need
   // not be a power of two. When the packet lock is active, only the locked
   // channel is served.
   always_comb begin
      logic [CW-1:0] cand;
      pick_s  = CW'(0);
      found_s = 1'b0;
      cand    = rr_r;
      for (int i = 0; i < NCH; i++) begin
         cand = (cand == LAST_CH) ? CW'(0) : cand + CW'(1);
         if (!found_s && nonempty_s[cand]) begin
            pick_s  = cand;
            found_s = 1'b1;
         end else begin
            pick_s  = pick_s;
            found_s = found_s;
         end
      end
`ifdef INTF_ARB_PKT_EN
      if (state_r == LOCKED) begin
         pick_s  = lock_ch_r;
         found_s = nonempty_s[lock_ch_r];
      end else begin
         pick_s  = pick_s;
         found_s = found_s;
      end
`endif
   end

   assign load_s = !out_valid | out_ready;
   assign take_s = load_s & found_s;

   // Pop exactly the picked channel when the output stage takes a beat.
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         pop_s[c] = take_s && (pick_s == CW'(c));
      end
   end

   // Output register and round-robin pointer. The pointer resets to NCH-1 so
   // that channel 0 has priority first.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= W'(0);
         out_chan  <= CW'(0);
         out_last  <= 1'b0;
         rr_r      <= LAST_CH;
      end else if (load_s) begin
         if (found_s) begin
            out_valid <= 1'b1;
            out_data  <= head_data_s[pick_s];
            out_chan  <= pick_s;
            out_last  <= head_last_s[pick_s];
            rr_r      <= pick_s;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_intf_array_rr_arb.sv
// Directed self-checking bench for intf_array_rr_arb (NCH=3, W=8, DEPTH=4).
// Packet-lock expectations follow INTF_ARB_PKT_EN when the macro is defined.
module tb_intf_array_rr_arb;

   localparam int NCH   = 3;
   localparam int W     = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(NCH);
   localparam int FW    = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst;
   logic [NCH-1:0]    in_valid;
   logic [NCH-1:0]    in_ready;
   logic [NCH*W-1:0]  in_data;
   logic [NCH-1:0]    in_last;
   logic              out_valid;
   logic              out_ready;
   logic [W-1:0]      out_data;
   logic [CW-1:0]     out_chan;
   logic              out_last;
   logic [NCH*FW-1:0] fill;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_d [6];
   logic       exp_v [6];

   intf_array_rr_arb #(.NCH(NCH), .W(W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_chan(out_chan), .out_last(out_last), .fill(fill)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 3'b000;
      in_data   = 24'h0;
      in_last   = 3'b000;
      out_ready = 1'b0;

      // 1: reset
      step();
      step();
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_in_ready", 32'(in_ready), 32'h7);
      check_val("rst_fill", 32'(fill), 32'd0);
      check_val("rst_out_data", 32'(out_data), 32'd0);
      rst = 1'b0;
      step();

      // 2: fairness, every channel gets 4 beats
      for (int k = 0; k < 4; k++) begin
         in_valid = 3'b111;
         in_last  = 3'b111;
         in_data  = {8'(8'h20 + k), 8'(8'h10 + k), 8'(8'h00 + k)};
         step();
      end
      in_valid  = 3'b000;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         check_val("fair_valid", 32'(out_valid), 32'd1);
         check_val("fair_chan", 32'(out_chan), 32'(i % 3));
         check_val("fair_data", 32'(out_data), 32'(16 * (i % 3) + i / 3));
         step();
      end
      check_val("fair_drained_valid", 32'(out_valid), 32'd0);
      check_val("fair_drained_fill", 32'(fill), 32'd0);

      // 3: full FIFO on channel 1
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         in_valid = 3'b010;
         in_last  = 3'b010;
         in_data  = {8'h00, 8'(8'h30 + k), 8'h00};
         step();
      end
      check_val("full_fill", 32'(fill[5:3]), 32'd4);
      check_val("full_in_ready", 32'(in_ready[1]), 32'd0);
      check_val("full_out_data", 32'(out_data), 32'h30);
      in_data = {8'h00, 8'h55, 8'h00};
      step();
      check_val("full_refuse_fill", 32'(fill[5:3]), 32'd4);
      in_data   = {8'h00, 8'h66, 8'h00};
      out_ready = 1'b1;
      step();
      in_valid = 3'b000;
      check_val("full_pushpop_fill", 32'(fill[5:3]), 32'd3);
      check_val("full_pushpop_data", 32'(out_data), 32'h31);
      for (int k = 2; k < 5; k++) begin
         step();
         check_val("full_drain_valid", 32'(out_valid), 32'd1);
         check_val("full_drain_data", 32'(out_data), 32'(8'h30 + k));
      end
      step();
      check_val("full_empty_valid", 32'(out_valid), 32'd0);

      // 4: backpressure holds the output stable
      out_ready = 1'b0;
      in_valid  = 3'b100;
      in_last   = 3'b100;
      in_data   = {8'h77, 8'h00, 8'h00};
      step();
      in_data = {8'h78, 8'h00, 8'h00};
      step();
      in_valid = 3'b000;
      check_val("bp_valid", 32'(out_valid), 32'd1);
      check_val("bp_data", 32'(out_data), 32'h77);
      check_val("bp_chan", 32'(out_chan), 32'd2);
      for (int i = 0; i < 3; i++) begin
         step();
         check_val("bp_hold_valid", 32'(out_valid), 32'd1);
         check_val("bp_hold_data", 32'(out_data), 32'h77);
         check_val("bp_hold_chan", 32'(out_chan), 32'd2);
      end
      out_ready = 1'b1;
      step();
      check_val("bp_next_data", 32'(out_data), 32'h78);
      step();
      check_val("bp_empty_valid", 32'(out_valid), 32'd0);

      // 5: packet lock, A(last=0) and C on ch0/ch1, B arrives late
`ifdef INTF_ARB_PKT_EN
      exp_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      exp_d = '{8'hA1, 8'h00, 8'h00, 8'hB2, 8'hC3, 8'h00};
`else
      exp_v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      exp_d = '{8'hA1, 8'hC3, 8'h00, 8'hB2, 8'h00, 8'h00};
`endif
      in_valid = 3'b011;
      in_last  = 3'b010;
      in_data  = {8'h00, 8'hC3, 8'hA1};
      step();
      in_valid = 3'b000;
      step();
      for (int j = 0; j < 6; j++) begin
         check_val($sformatf("pkt_valid_%0d", j), 32'(out_valid), 32'(exp_v[j]));
         if (exp_v[j]) begin
            check_val($sformatf("pkt_data_%0d", j), 32'(out_data), 32'(exp_d[j]));
         end
         if (j == 1) begin
            in_valid = 3'b001;
            in_last  = 3'b001;
            in_data  = {8'h00, 8'h00, 8'hB2};
         end
         if (j == 2) begin
            in_valid = 3'b000;
         end
         step();
      end

      // 6: reset mid-operation flushes everything
      out_ready = 1'b0;
      in_last   = 3'b001;
      for (int k = 0; k < 3; k++) begin
         in_valid = 3'b001;
         in_data  = {8'h00, 8'h00, 8'(8'h90 + k)};
         step();
      end
      in_valid = 3'b000;
      check_val("mid_pre_valid", 32'(out_valid), 32'd1);
      check_val("mid_pre_fill", 32'(fill[2:0]), 32'd2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_val("mid_rst_valid", 32'(out_valid), 32'd0);
      check_val("mid_rst_fill", 32'(fill), 32'd0);
      check_val("mid_rst_in_ready", 32'(in_ready), 32'h7);
      check_val("mid_rst_data", 32'(out_data), 32'd0);
      out_ready = 1'b1;
      step();
      check_val("mid_after_valid", 32'(out_valid), 32'd0);
      check_val("mid_after_fill", 32'(fill), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
